bin2bcd_hex6: RTL and testbench

BIN2BCD_HEX6 -- requirements
Module: bin2bcd_hex6

---
 rtl/bin2bcd_hex6.sv | 150 +++++++++++++++
 tb/tb_bin2bcd_hex6.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_hex6.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_hex6
// Purpose  : 20-bit binary to 6-digit BCD (serial double-dabble) with seven-
//            segment decode; BIN2BCD_LEADING_ZERO_BLANK_EN enables blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_hex6 #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] bcd,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        done,
    output logic        ovf
);

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [19:0] MAX_VAL   = 20'd999999;
    localparam logic [4:0]  LAST_ITER = 5'd19;
    localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [6:0]  SEG_ZERO  = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
    localparam logic [6:0]  SEG_UPPER_RST = BLANK_EN ? SEG_OFF : SEG_ZERO;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  iter;
    logic [19:0] sh_bin;
    logic [23:0] sh_bcd;
    logic [23:0] bcd_adj;
    logic [23:0] bcd_step;
    logic        nz;
    logic [6:0]  hex_nxt [6];
    logic [6:0]  hex_r   [6];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? p : ~p;
    endfunction

    // One double-dabble step: correct nibbles >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = sh_bcd;
        for (int i = 0; i < 6; i++) begin
            if (sh_bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[22:0], sh_bin[19]};
    end

    // Walk from the top digit down; blank while no nonzero digit seen yet.
    always_comb begin
        nz = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            nz = nz | (bcd_step[4*i +: 4] != 4'd0);
            hex_nxt[i] = (BLANK_EN && (i != 0) && !nz) ? SEG_OFF
                                                       : seg7(bcd_step[4*i +: 4]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CONV;
            CONV:    if (iter == LAST_ITER) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        in_ready = (state == IDLE);
        done     = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            iter   <= 5'd0;
            sh_bin <= 20'd0;
            sh_bcd <= 24'd0;
            bcd    <= 24'd0;
            ovf    <= 1'b0;
            hex_r[0] <= SEG_ZERO;
            for (int i = 1; i < 6; i++) hex_r[i] <= SEG_UPPER_RST;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_bin <= (bin > MAX_VAL) ? MAX_VAL : bin;
                        sh_bcd <= 24'd0;
                        ovf    <= (bin > MAX_VAL);
                        iter   <= 5'd0;
                    end
                end
                CONV: begin
                    sh_bin <= {sh_bin[18:0], 1'b0};
                    sh_bcd <= bcd_step;
                    iter   <= iter + 5'd1;
                    // Results become visible exactly while done is high.
                    if (iter == LAST_ITER) begin
                        bcd <= bcd_step;
                        for (int i = 0; i < 6; i++) hex_r[i] <= hex_nxt[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hex0 = hex_r[0];
    assign hex1 = hex_r[1];
    assign hex2 = hex_r[2];
    assign hex3 = hex_r[3];
    assign hex4 = hex_r[4];
    assign hex5 = hex_r[5];

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_hex6.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_hex6
// Purpose  : Scoreboard bench for bin2bcd_hex6 (active-low and active-high).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_hex6;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    localparam logic [6:0] SEG_LO [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
        7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] bin;
    logic        in_valid;
    logic        in_ready, done, ovf;
    logic [23:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        in_ready_b, done_b, ovf_b;
    logic [23:0] bcd_b;
    logic [6:0]  hb0, hb1, hb2, hb3, hb4, hb5;
    logic [6:0]  hx [6];
    logic [6:0]  hxb [6];

    always #5 clk = ~clk;

    bin2bcd_hex6 #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bin(bin), .in_valid(in_valid),
        .in_ready(in_ready), .bcd(bcd), .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .hex3(hex3), .hex4(hex4), .hex5(hex5), .done(done), .ovf(ovf));

    bin2bcd_hex6 #(.SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bin(bin), .in_valid(in_valid),
        .in_ready(in_ready_b), .bcd(bcd_b), .hex0(hb0), .hex1(hb1), .hex2(hb2),
        .hex3(hb3), .hex4(hb4), .hex5(hb5), .done(done_b), .ovf(ovf_b));

    assign hx  = '{hex0, hex1, hex2, hex3, hex4, hex5};
    assign hxb = '{hb0, hb1, hb2, hb3, hb4, hb5};

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          have_acc = 1'b0;
    logic [23:0] cur_bcd = 24'd0;
    logic        acc_ovf = 1'b0;

    function automatic logic [23:0] mbcd(input logic [19:0] b);
        int n;
        logic [23:0] r;
        n = (b > 20'd999999) ? 999999 : int'(b);
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] mhex(input logic [23:0] v, input int i, input bit lo);
        logic [6:0] p;
        logic [3:0] d;
        d = v[4*i +: 4];
        p = SEG_LO[d];
        if (BLANK && i > 0 && (v >> (4*i)) == 24'd0) p = 7'b1111111;
        return lo ? p : ~p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("bcd", 32'(bcd), 32'(cur_bcd));
        chk("ovf", 32'(ovf), 32'(acc_ovf));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hex%0d", i), 32'(hx[i]), 32'(mhex(cur_bcd, i, 1'b1)));
            chk($sformatf("hexb%0d", i), 32'(hxb[i]), 32'(mhex(cur_bcd, i, 1'b0)));
        end
    endtask

    // One cycle: sample at negedge against the model, then drive the next inputs.
    task automatic tick(input logic v, input logic [19:0] b);
        exp_t e;
        bit   busy;
        @(negedge clk);
        cyc++;
        busy = have_acc && (cyc - acc_cyc) <= 21;
        chk("done", 32'(done), 32'(have_acc && (cyc - acc_cyc) == 21));
        chk("in_ready", 32'(in_ready), 32'(!busy));
        if (done) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                cur_bcd = e.bcd;
                chk("ovf_at_done", 32'(ovf), 32'(e.ovf));
            end
        end
        check_outputs();
        in_valid = v;
        bin      = b;
        if (v && !busy) begin
            e.bcd = mbcd(b);
            e.ovf = (b > 20'd999999);
            sb.push_back(e);
            acc_ovf  = e.ovf;
            acc_cyc  = cyc;
            have_acc = 1'b1;
        end
    endtask

    task automatic request(input logic [19:0] b);
        tick(1'b1, b);
        repeat (22) tick(1'b0, 20'($urandom_range(0, 20'hFFFFF)));
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        bin      = 20'd0;
        #12;
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_hex0", 32'(hex0), 32'(7'b1000000));
        chk("rst_hex5", 32'(hex5), BLANK ? 32'(7'b1111111) : 32'(7'b1000000));
        @(negedge clk) reset_n = 1'b1;

        request(20'd0);
        chk("zero_bcd", 32'(bcd), 32'h000000);
        chk("zero_hex0", 32'(hex0), 32'(7'b1000000));
        chk("zero_hex5", 32'(hex5), BLANK ? 32'(7'b1111111) : 32'(7'b1000000));

        request(20'd123456);
        chk("d123456_bcd", 32'(bcd), 32'h123456);
        chk("d123456_ovf", 32'(ovf), 32'd0);
        chk("d123456_hex0", 32'(hex0), 32'(7'b0000010));

        request(20'hFFFFF);
        chk("max_bcd", 32'(bcd), 32'h999999);
        chk("max_ovf", 32'(ovf), 32'd1);
        request(20'd999999);
        chk("lim_bcd", 32'(bcd), 32'h999999);
        chk("lim_ovf", 32'(ovf), 32'd0);

        request(20'd8);
        chk("b8_hexb0", 32'(hb0), 32'(7'b1111111));
        request(20'd700);

        // in_valid held high with bin changing every cycle
        repeat (70) tick(1'b1, 20'($urandom_range(0, 20'hFFFFF)));
        repeat (25) tick(1'b0, 20'd0);

        // Asynchronous reset part-way through a conversion
        tick(1'b1, 20'd54321);
        repeat (11) tick(1'b0, 20'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_hex0", 32'(hex0), 32'(7'b1000000));
        sb.delete();
        have_acc = 1'b0;
        cur_bcd  = 24'd0;
        acc_ovf  = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        repeat (25) tick(1'b0, 20'd0);
        request(20'd987654);
        chk("post_rst_bcd", 32'(bcd), 32'h987654);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
